// File: rtl/izh_neuron_bank.sv
// izh_neuron_bank: time-multiplexed Izhikevich v/u update engine.
// Optional refractory counters are enabled with `define REFRACTORY_EN.
module izh_neuron_bank #(
  parameter int N_NEURONS = 16,
  parameter int IDX_W     = $clog2(N_NEURONS),
  parameter int W         = 17,
  parameter int F         = 8,
  parameter int A         = 5,
  parameter int B         = 51,
  parameter int C         = -16640,
  parameter int D         = 512,
  parameter int VPEAK     = 7680,
  parameter int U_INIT    = -3328
`ifdef REFRACTORY_EN
  ,
  parameter int REFRAC    = 2
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_start,
  output logic             busy,
  output logic             step_done,
  output logic [IDX_W-1:0] cur_idx,
  input  logic [W-1:0]     cur_in,
  input  logic             cur_valid,
  output logic             spike_valid,
  output logic [IDX_W-1:0] spike_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [W-1:0]     rd_v,
  output logic [W-1:0]     rd_u
);

  localparam int XW = 2 * W;

  typedef logic signed [W-1:0]  st_t;
  typedef logic signed [XW-1:0] wd_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NEURONS - 1);

  localparam st_t C_S     = st_t'(C);
  localparam st_t U_S     = st_t'(U_INIT);
  localparam st_t VPEAK_S = st_t'(VPEAK);

  localparam wd_t K10  = wd_t'(10);
  localparam wd_t K5   = wd_t'(5);
  localparam wd_t K140 = wd_t'(140 <<< F);
  localparam wd_t KA   = wd_t'(A);
  localparam wd_t KB   = wd_t'(B);
  localparam wd_t KD   = wd_t'(D);
  localparam wd_t MAXV = wd_t'((1 <<< (W - 1)) - 1);
  localparam wd_t MINV = wd_t'(-(1 <<< (W - 1)));

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             we;

  st_t v_q [N_NEURONS];
  st_t u_q [N_NEURONS];

  logic             done_q;
  logic             spk_q;
  logic [IDX_W-1:0] spk_idx_q;
  st_t              rd_v_q;
  st_t              rd_u_q;

  wd_t v_x, u_x, c_x;
  wd_t vv, dv, bv;
  st_t vn, un, ub;
  logic fire;
  logic refr;

  function automatic wd_t sext(input st_t x);
    return {{W{x[W-1]}}, x};
  endfunction

  function automatic st_t sat(input wd_t x);
    if (x > MAXV) return MAXV[W-1:0];
    if (x < MINV) return MINV[W-1:0];
    return x[W-1:0];
  endfunction

`ifdef REFRACTORY_EN
  localparam int RCW = $clog2(REFRAC + 1);

  logic [RCW-1:0] rc_q [N_NEURONS];

  assign refr = (rc_q[idx_q] != '0);

  // Refractory countdown for the neuron being updated
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        rc_q[i] <= '0;
      end
    end else if (we) begin
      if (fire) begin
        rc_q[idx_q] <= RCW'(REFRAC);
      end else if (refr) begin
        rc_q[idx_q] <= rc_q[idx_q] - 1'b1;
      end
    end
  end
`else
  assign refr = 1'b0;
`endif

  // Euler step for the currently selected neuron
  always_comb begin
    v_x  = sext(v_q[idx_q]);
    u_x  = sext(u_q[idx_q]);
    c_x  = refr ? '0 : sext(cur_in);
    vv   = (v_x * v_x) >>> F;
    dv   = ((vv * K10) >>> F) + (K5 * v_x) + K140 - u_x + c_x;
    vn   = sat(v_x + dv);
    bv   = (KB * v_x) >>> F;
    un   = sat(u_x + ((KA * (bv - u_x)) >>> F));
    ub   = sat(sext(un) + KD);
    fire = !refr && (vn >= VPEAK_S);
  end

  // Sweep FSM state and neuron index register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Sweep sequencing; RUN advances only on valid current
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (step_start) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (cur_valid) begin
          we = 1'b1;
          if (idx_q == LAST) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Neuron state array write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i] <= C_S;
        u_q[i] <= U_S;
      end
    end else if (we) begin
      v_q[idx_q] <= fire ? C_S : vn;
      u_q[idx_q] <= fire ? ub : un;
    end
  end

  // Registered completion, spike and readback outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q    <= 1'b0;
      spk_q     <= 1'b0;
      spk_idx_q <= '0;
      rd_v_q    <= C_S;
      rd_u_q    <= U_S;
    end else begin
      done_q <= (state_q == DONE);
      spk_q  <= we && fire;
      if (we && fire) begin
        spk_idx_q <= idx_q;
      end
      rd_v_q <= v_q[rd_idx];
      rd_u_q <= u_q[rd_idx];
    end
  end

  assign busy        = (state_q != IDLE);
  assign step_done   = done_q;
  assign cur_idx     = idx_q;
  assign spike_valid = spk_q;
  assign spike_idx   = spk_idx_q;
  assign rd_v        = rd_v_q;
  assign rd_u        = rd_u_q;

endmodule

// File: tb/tb_izh_neuron_bank.sv
// tb_izh_neuron_bank: directed checks of the Izhikevich neuron bank.
// Refractory expectations switch with `define REFRACTORY_EN.
module tb_izh_neuron_bank;

  localparam int N  = 16;
  localparam int IW = 4;
  localparam int W  = 17;
  localparam int CV = -16640;
  localparam int UI = -3328;

  logic          clk = 1'b0;
  logic          reset;
  logic          step_start;
  logic          busy;
  logic          step_done;
  logic [IW-1:0] cur_idx;
  logic [W-1:0]  cur_in;
  logic          cur_valid;
  logic          spike_valid;
  logic [IW-1:0] spike_idx;
  logic [IW-1:0] rd_idx;
  logic [W-1:0]  rd_v;
  logic [W-1:0]  rd_u;

  logic          hot_en;
  logic [IW-1:0] hot_idx;
  logic [W-1:0]  hot_val;

  int checks = 0;
  int errors = 0;

  assign cur_in = (hot_en && cur_idx == hot_idx) ? hot_val : '0;

  always #5 clk = ~clk;

  izh_neuron_bank dut (
    .clk         (clk),
    .reset       (reset),
    .step_start  (step_start),
    .busy        (busy),
    .step_done   (step_done),
    .cur_idx     (cur_idx),
    .cur_in      (cur_in),
    .cur_valid   (cur_valid),
    .spike_valid (spike_valid),
    .spike_idx   (spike_idx),
    .rd_idx      (rd_idx),
    .rd_v        (rd_v),
    .rd_u        (rd_u)
  );

  function automatic logic signed [31:0] sx(input logic [W-1:0] x);
    return {{(32 - W){x[W-1]}}, x};
  endfunction

  task automatic check(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    step_start = 1'b0;
    cur_valid  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic rd(input int i, output int v, output int u);
    rd_idx = IW'(i);
    tick();
    v = sx(rd_v);
    u = sx(rd_u);
  endtask

  task automatic sweep(input int stall_at, input int stall_len,
                       input int poke_at, output int cyc,
                       output int nspk, output int last);
    int stalled;
    logic st;
    stalled = 0;
    cyc     = 0;
    nspk    = 0;
    last    = -1;
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    while (!step_done && cyc < 200) begin
      st = (int'(cur_idx) == stall_at) && (stalled < stall_len);
      cur_valid  = !st;
      step_start = (cyc == poke_at);
      if (st) stalled++;
      tick();
      cyc++;
      if (st) check("stall_hold", 32'(cur_idx), stall_at);
      if (spike_valid) begin
        nspk++;
        last = int'(spike_idx);
      end
    end
    step_start = 1'b0;
    cur_valid  = 1'b0;
    if (!step_done) check("sweep_timeout", 0, 1);
  endtask

  initial begin
    int v, u, cyc, nspk, last, cnt;
    int exp_spk [3];
    int exp_v2, exp_u2;
    hot_en  = 1'b0;
    hot_idx = '0;
    hot_val = '0;
    rd_idx  = '0;

    // reset state
    do_reset();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(step_done), 0);
    check("rst_spk", 32'(spike_valid), 0);
    check("rst_spk_idx", 32'(spike_idx), 0);
    check("rst_cur_idx", 32'(cur_idx), 0);
    check("rst_rd_v", sx(rd_v), CV);
    check("rst_rd_u", sx(rd_u), UI);
    for (int i = 0; i < N; i++) begin
      rd(i, v, u);
      check($sformatf("rst_v%0d", i), v, CV);
      check($sformatf("rst_u%0d", i), u, UI);
    end

    // zero-current sweep, with an ignored step_start mid-sweep
    sweep(-1, 0, 5, cyc, nspk, last);
    check("t2_cycles", cyc, 17);
    check("t2_nspk", nspk, 0);
    tick();
    check("t2_done_pulse", 32'(step_done), 0);
    check("t2_busy", 32'(busy), 0);
    rd(0, v, u);
    check("t2_v0", v, -18422);
    check("t2_u0", u, -3328);
    rd(15, v, u);
    check("t2_v15", v, -18422);
    check("t2_u15", u, -3328);

    // strong current on neuron 3 fires it
    do_reset();
    hot_en  = 1'b1;
    hot_idx = 4'd3;
    hot_val = 17'd30720;
    sweep(-1, 0, -1, cyc, nspk, last);
    check("t3_nspk", nspk, 1);
    check("t3_spk_idx", last, 3);
    rd(3, v, u);
    check("t3_v3", v, -16640);
    check("t3_u3", u, -2816);
    rd(2, v, u);
    check("t3_v2", v, -18422);

    // held input over further steps
`ifdef REFRACTORY_EN
    exp_spk = '{0, 0, 1};
    exp_v2  = -18934;
    exp_u2  = -2826;
`else
    exp_spk = '{1, 1, 1};
    exp_v2  = -16640;
    exp_u2  = -2314;
`endif
    for (int s = 0; s < 3; s++) begin
      sweep(-1, 0, -1, cyc, nspk, last);
      check($sformatf("t6_nspk_step%0d", s + 2), nspk, exp_spk[s]);
      if (s == 0) begin
        rd(3, v, u);
        check("t6_v3_step2", v, exp_v2);
        check("t6_u3_step2", u, exp_u2);
      end
    end
    check("t6_last_idx", last, 3);
    hot_en = 1'b0;

    // stall three cycles at neuron 5
    do_reset();
    sweep(5, 3, -1, cyc, nspk, last);
    check("t4_cycles", cyc, 20);
    check("t4_nspk", nspk, 0);
    rd(0, v, u);
    check("t4_v0", v, -18422);
    check("t4_u0", u, -3328);
    rd(5, v, u);
    check("t4_v5", v, -18422);

    // reset in the middle of a sweep
    do_reset();
    rd_idx     = '0;
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    cur_valid  = 1'b1;
    cnt = 0;
    while (cur_idx != 4'd7 && cnt < 50) begin
      tick();
      cnt++;
    end
    check("t5_reach7", 32'(cur_idx), 7);
    check("t5_pre_v0", sx(rd_v), -18422);
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    cur_valid = 1'b1;
    check("t5_busy", 32'(busy), 0);
    check("t5_done", 32'(step_done), 0);
    check("t5_cur_idx", 32'(cur_idx), 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (step_done || busy) cnt++;
    end
    cur_valid = 1'b0;
    check("t5_no_done", cnt, 0);
    rd(0, v, u);
    check("t5_v0", v, CV);
    check("t5_u0", u, UI);
    rd(6, v, u);
    check("t5_v6", v, CV);
    check("t5_u6", u, UI);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
